// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer for the IF stage. Each entry holds
//   a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.
//   Two independent combinational lookup ports serve the PC+2 and PC+4
//   fall-through addresses. Resolved branches from EX update the table and
//   the branch / misprediction statistics counters.
//   With MODE=1 the table index is the raw address index XORed with a
//   global history register (gshare). With MODE=0 the raw index is used
//   directly (bimodal).
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   stall_i                     pipeline stall, freezes table/GHR/statistics
//   rd_addr2_i/rd_hit2_o/rd_target2_o   lookup port for PC+2
//   rd_addr4_i/rd_hit4_o/rd_target4_o   lookup port for PC+4
//   upd_valid_i, upd_taken_i, upd_miss_i, upd_addr_i, upd_target_i
//                               resolved branch from EX
//   branch_cnt_o, mispred_cnt_o saturating statistics counters
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int MODE    = 0,
  parameter int GHR_W   = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic [31:0]      rd_addr2_i,
  output logic             rd_hit2_o,
  output logic [31:0]      rd_target2_o,
  input  logic [31:0]      rd_addr4_i,
  output logic             rd_hit4_o,
  output logic [31:0]      rd_target4_o,
  input  logic             upd_valid_i,
  input  logic             upd_taken_i,
  input  logic             upd_miss_i,
  input  logic [31:0]      upd_addr_i,
  input  logic [31:0]      upd_target_i,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic [IDX_W-1:0] hist_idx;
  logic [IDX_W-1:0] idx2;
  logic [IDX_W-1:0] idx4;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] tag2;
  logic [TAG_W-1:0] tag4;
  logic [TAG_W-1:0] upd_tag;
  logic             hit2;
  logic             hit4;
  logic             upd_match;
  logic             upd_en;

  // Bit 0 and the bits above the tag never take part in indexing; folding
  // the full buses here keeps them formally consumed.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr2_i, rd_addr4_i, upd_addr_i};

  // An update is only accepted when the pipeline is moving.
  assign upd_en = upd_valid_i & ~stall_i;

  // The history register only exists in gshare mode. Its current value
  // feeds both lookup and update indexing, so a lookup in the same cycle as
  // an update sees the same history the update uses.
  generate
    if (MODE == 1) begin : g_gshare
      logic [GHR_W-1:0] ghr_q;

      // Shift the resolved outcome in at the LSB on every accepted update;
      // the cast drops the oldest bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr_q <= '0;
        end else if (upd_en) begin
          ghr_q <= GHR_W'({ghr_q, upd_taken_i});
        end
      end

      assign hist_idx = IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign hist_idx = '0;
    end
  endgenerate

  // Halfword-aligned index and tag extraction for all three address paths.
  assign idx2    = rd_addr2_i[IDX_W:1] ^ hist_idx;
  assign idx4    = rd_addr4_i[IDX_W:1] ^ hist_idx;
  assign upd_idx = upd_addr_i[IDX_W:1] ^ hist_idx;
  assign tag2    = rd_addr2_i[IDX_W+TAG_W:IDX_W+1];
  assign tag4    = rd_addr4_i[IDX_W+TAG_W:IDX_W+1];
  assign upd_tag = upd_addr_i[IDX_W+TAG_W:IDX_W+1];

  // Lookups read the registered table directly, so a same-cycle update is
  // never bypassed. Predict taken only in the upper half of the counter.
  assign hit2 = valid_q[idx2] & (tag_q[idx2] == tag2) & ctr_q[idx2][1];
  assign hit4 = valid_q[idx4] & (tag_q[idx4] == tag4) & ctr_q[idx4][1];

  assign rd_hit2_o    = hit2;
  assign rd_hit4_o    = hit4;
  assign rd_target2_o = hit2 ? target_q[idx2] : 32'd0;
  assign rd_target4_o = hit4 ? target_q[idx4] : 32'd0;

  assign upd_match = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

  // Table storage. A matching entry trains its counter (and refreshes the
  // target on taken); a miss allocates only on a taken branch, starting
  // weakly-taken so the new entry predicts taken immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_match) begin
        if (upd_taken_i) begin
          target_q[upd_idx] <= upd_target_i;
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  // Statistics counters stick at all-ones instead of wrapping, so a long
  // run never reports a misleadingly small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (upd_en) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (upd_miss_i && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
//   Directed bench for branch_target_predictor. Two instances share the
//   stimulus: dut_b is bimodal with 4-bit statistics counters (for the
//   saturation case), dut_g is gshare with a 4-bit history.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] rd_addr2;
  logic [31:0] rd_addr4;
  logic        upd_valid;
  logic        upd_taken;
  logic        upd_miss;
  logic [31:0] upd_addr;
  logic [31:0] upd_target;

  logic        b_hit2;
  logic [31:0] b_tgt2;
  logic        b_hit4;
  logic [31:0] b_tgt4;
  logic [3:0]  b_bcnt;
  logic [3:0]  b_mcnt;

  logic        g_hit2;
  logic [31:0] g_tgt2;
  logic        g_hit4;
  logic [31:0] g_tgt4;
  logic [31:0] g_bcnt;
  logic [31:0] g_mcnt;

  int checks = 0;
  int fails  = 0;

  branch_target_predictor #(
    .ENTRIES(16), .TAG_W(8), .MODE(0), .GHR_W(4), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .rd_addr2_i(rd_addr2), .rd_hit2_o(b_hit2), .rd_target2_o(b_tgt2),
    .rd_addr4_i(rd_addr4), .rd_hit4_o(b_hit4), .rd_target4_o(b_tgt4),
    .upd_valid_i(upd_valid), .upd_taken_i(upd_taken), .upd_miss_i(upd_miss),
    .upd_addr_i(upd_addr), .upd_target_i(upd_target),
    .branch_cnt_o(b_bcnt), .mispred_cnt_o(b_mcnt)
  );

  branch_target_predictor #(
    .ENTRIES(16), .TAG_W(8), .MODE(1), .GHR_W(4), .CNT_W(32)
  ) dut_g (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .rd_addr2_i(rd_addr2), .rd_hit2_o(g_hit2), .rd_target2_o(g_tgt2),
    .rd_addr4_i(rd_addr4), .rd_hit4_o(g_hit4), .rd_target4_o(g_tgt4),
    .upd_valid_i(upd_valid), .upd_taken_i(upd_taken), .upd_miss_i(upd_miss),
    .upd_addr_i(upd_addr), .upd_target_i(upd_target),
    .branch_cnt_o(g_bcnt), .mispred_cnt_o(g_mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accepted-or-stalled update across one rising edge; returns 1 time
  // unit after the edge so the caller samples away from it.
  task automatic upd(input logic [31:0] a, input logic t,
                     input logic [31:0] tg, input logic m);
    upd_valid  = 1'b1;
    upd_addr   = a;
    upd_taken  = t;
    upd_target = tg;
    upd_miss   = m;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    upd_miss  = 1'b0;
  endtask

  // Pulse reset well away from any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rd_addr2 = 32'h0000_0104;
    rd_addr4 = 32'h0000_0104;
    #1;
    checks++;
    if (b_hit2 !== 1'b0 || b_hit4 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_hit: got %b/%b expected 0/0", b_hit2, b_hit4);
    end
    checks++;
    if (b_tgt2 !== 32'd0 || b_tgt4 !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_target: got %h/%h expected 0/0", b_tgt2, b_tgt4);
    end
    checks++;
    if (b_bcnt !== 4'd0 || b_mcnt !== 4'd0 || g_bcnt !== 32'd0 || g_mcnt !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_counters: got %0d/%0d/%0d/%0d expected 0", b_bcnt, b_mcnt, g_bcnt, g_mcnt);
    end
  endtask

  task automatic test_allocate();
    upd(32'h0000_0104, 1'b1, 32'h0000_0200, 1'b0);
    rd_addr4 = 32'h0000_0104;
    rd_addr2 = 32'h0000_1104;
    #1;
    checks++;
    if (b_hit4 !== 1'b1 || b_tgt4 !== 32'h0000_0200) begin
      fails++;
      $display("[TB] FAIL alloc_hit4: got %b %h expected 1 00000200", b_hit4, b_tgt4);
    end
    checks++;
    if (b_hit2 !== 1'b0 || b_tgt2 !== 32'd0) begin
      fails++;
      $display("[TB] FAIL alloc_tag_miss: got %b %h expected 0 00000000", b_hit2, b_tgt2);
    end
    rd_addr2 = 32'h0000_0104;
    #1;
    checks++;
    if (b_hit2 !== 1'b1 || b_tgt2 !== 32'h0000_0200) begin
      fails++;
      $display("[TB] FAIL alloc_same_entry: got %b %h expected 1 00000200", b_hit2, b_tgt2);
    end
    upd_valid  = 1'b1;
    upd_addr   = 32'h0000_0104;
    upd_taken  = 1'b1;
    upd_target = 32'h0000_0300;
    #1;
    checks++;
    if (b_tgt4 !== 32'h0000_0200) begin
      fails++;
      $display("[TB] FAIL no_bypass: got %h expected 00000200", b_tgt4);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    checks++;
    if (b_hit4 !== 1'b1 || b_tgt4 !== 32'h0000_0300) begin
      fails++;
      $display("[TB] FAIL retarget: got %b %h expected 1 00000300", b_hit4, b_tgt4);
    end
  endtask

  task automatic test_hysteresis();
    rd_addr4 = 32'h0000_0108;
    upd(32'h0000_0108, 1'b1, 32'h0000_0400, 1'b0);
    checks++;
    if (b_hit4 !== 1'b1 || b_tgt4 !== 32'h0000_0400) begin
      fails++;
      $display("[TB] FAIL hyst_alloc: got %b %h expected 1 00000400", b_hit4, b_tgt4);
    end
    upd(32'h0000_0108, 1'b0, 32'h0000_0000, 1'b1);
    checks++;
    if (b_hit4 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hyst_n1: got %b expected 0", b_hit4);
    end
    upd(32'h0000_0108, 1'b0, 32'h0000_0000, 1'b0);
    upd(32'h0000_0108, 1'b0, 32'h0000_0000, 1'b0);
    checks++;
    if (b_hit4 !== 1'b0 || b_tgt4 !== 32'd0) begin
      fails++;
      $display("[TB] FAIL hyst_floor: got %b %h expected 0 00000000", b_hit4, b_tgt4);
    end
    upd(32'h0000_0108, 1'b1, 32'h0000_0480, 1'b1);
    checks++;
    if (b_hit4 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hyst_t1: got %b expected 0", b_hit4);
    end
    upd(32'h0000_0108, 1'b1, 32'h0000_0480, 1'b1);
    checks++;
    if (b_hit4 !== 1'b1 || b_tgt4 !== 32'h0000_0480) begin
      fails++;
      $display("[TB] FAIL hyst_t2: got %b %h expected 1 00000480", b_hit4, b_tgt4);
    end
  endtask

  task automatic test_stall_stats();
    do_reset();
    rd_addr4 = 32'h0000_0104;
    stall = 1'b1;
    upd(32'h0000_0104, 1'b1, 32'h0000_0200, 1'b1);
    checks++;
    if (b_bcnt !== 4'd0 || b_mcnt !== 4'd0 || b_hit4 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_hold: got cnt %0d/%0d hit %b expected 0/0 hit 0", b_bcnt, b_mcnt, b_hit4);
    end
    stall = 1'b0;
    upd(32'h0000_0104, 1'b1, 32'h0000_0200, 1'b1);
    checks++;
    if (b_bcnt !== 4'd1 || b_mcnt !== 4'd1 || b_hit4 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stall_release: got cnt %0d/%0d hit %b expected 1/1 hit 1", b_bcnt, b_mcnt, b_hit4);
    end
    // 19 more accepted updates: branches 20 total, mispredictions 16 total
    for (int i = 0; i < 19; i++) begin
      upd(32'h0000_0010, 1'b0, 32'h0000_0000, (i < 15));
    end
    checks++;
    if (b_bcnt !== 4'hF || b_mcnt !== 4'hF) begin
      fails++;
      $display("[TB] FAIL stats_saturate: got %h/%h expected F/F", b_bcnt, b_mcnt);
    end
    checks++;
    if (g_bcnt !== 32'd20 || g_mcnt !== 32'd16) begin
      fails++;
      $display("[TB] FAIL stats_wide: got %0d/%0d expected 20/16", g_bcnt, g_mcnt);
    end
  endtask

  task automatic test_gshare();
    do_reset();
    rd_addr2 = 32'h0000_0002;
    rd_addr4 = 32'h0000_0040;
    // history T,T,N,T -> 4'b1101
    upd(32'h0000_0040, 1'b1, 32'h0000_0800, 1'b0);
    upd(32'h0000_0040, 1'b1, 32'h0000_0800, 1'b0);
    upd(32'h0000_0040, 1'b0, 32'h0000_0800, 1'b0);
    upd(32'h0000_0040, 1'b1, 32'h0000_0800, 1'b0);
    // allocates index 1 ^ 13 = 12; history becomes 4'b1011
    upd(32'h0000_0002, 1'b1, 32'h0000_0900, 1'b0);
    checks++;
    if (g_hit2 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL gshare_other_hist: got %b expected 0", g_hit2);
    end
    // T,T,N,T again brings history back to 4'b1101 (indices 11,7,15,14)
    upd(32'h0000_0040, 1'b1, 32'h0000_0800, 1'b0);
    upd(32'h0000_0040, 1'b1, 32'h0000_0800, 1'b0);
    upd(32'h0000_0040, 1'b0, 32'h0000_0800, 1'b0);
    upd(32'h0000_0040, 1'b1, 32'h0000_0800, 1'b0);
    checks++;
    if (g_hit2 !== 1'b1 || g_tgt2 !== 32'h0000_0900) begin
      fails++;
      $display("[TB] FAIL gshare_hit: got %b %h expected 1 00000900", g_hit2, g_tgt2);
    end
    checks++;
    if (g_hit4 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL gshare_idx13: got %b expected 0", g_hit4);
    end
    checks++;
    if (b_hit4 !== 1'b1 || b_tgt4 !== 32'h0000_0800) begin
      fails++;
      $display("[TB] FAIL bimodal_shared: got %b %h expected 1 00000800", b_hit4, b_tgt4);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_hit4 !== 1'b0 || b_tgt4 !== 32'd0 || g_hit2 !== 1'b0 || g_tgt2 !== 32'd0) begin
      fails++;
      $display("[TB] FAIL midop_reset_hit: got %b %h %b %h expected 0", b_hit4, b_tgt4, g_hit2, g_tgt2);
    end
    checks++;
    if (g_bcnt !== 32'd0 || b_bcnt !== 4'd0) begin
      fails++;
      $display("[TB] FAIL midop_reset_cnt: got %0d/%0d expected 0/0", g_bcnt, b_bcnt);
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    stall      = 1'b0;
    rd_addr2   = 32'd0;
    rd_addr4   = 32'd0;
    upd_valid  = 1'b0;
    upd_taken  = 1'b0;
    upd_miss   = 1'b0;
    upd_addr   = 32'd0;
    upd_target = 32'd0;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_allocate();
    test_hysteresis();
    test_stall_stats();
    test_gshare();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
